// File: rtl/display_cmd_sched_if.sv
// Host command / VGA timing / component broadcast bundle for the display command scheduler.
// The master side is the host + timing generator; the slave side is the scheduler.
interface display_cmd_sched_if #(
  parameter int FIFO_DEPTH = 16
) ();
  logic                        cmd_valid;
  logic [31:0]                 cmd_data;
  logic                        cmd_ready;
  logic [9:0]                  hcount;
  logic [9:0]                  vcount;
  logic [31:0]                 writedata;
  logic                        active_buf;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        frame_done;

  modport master (
    output cmd_valid, cmd_data, hcount, vcount,
    input  cmd_ready, writedata, active_buf, fifo_count, frame_done
  );

  modport slave (
    input  cmd_valid, cmd_data, hcount, vcount,
    output cmd_ready, writedata, active_buf, fifo_count, frame_done
  );
endinterface

// File: rtl/display_cmd_sched.sv
// Queues host display commands and replays them onto the component bus during vblank,
// issuing a double-buffer flip when a commit marker is reached.
//
// state       | meaning
// IDLE        | active video, bus idle, waiting for vblank
// DRAIN       | vblank, popping one queued word per cycle
// FLUSH       | commit marker popped, broadcast flip and toggle active_buf
// WAIT_ACTIVE | frame finished (flip or empty queue), waiting for vblank to end
module display_cmd_sched #(
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [9:0] VBLANK_START = 10'd480
) (
  input logic               clk,
  input logic               reset,
  display_cmd_sched_if.slave bus
);
  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            CW         = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [3:0]    ACT_COMMIT = 4'b1111;
  localparam logic [3:0]    ACT_DRAW   = 4'b0001;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, WAIT_ACTIVE} state_t;

  state_t        r_state;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_writedata;
  logic          r_active_buf;
  logic          r_frame_done;

  logic          w_vblank;
  logic          w_empty;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head;
  logic          w_head_marker;
  logic [31:0]   w_cmd_out;
  logic [31:0]   w_flush_word;
  logic          w_unused_hcount;

  assign w_vblank        = (bus.vcount >= VBLANK_START);
  assign w_empty         = (r_count == '0);
  assign w_ready         = (r_count != FULL_CNT);
  assign w_push          = bus.cmd_valid && w_ready;
  assign w_pop           = (r_state == DRAIN) && w_vblank && !w_empty;
  assign w_head          = r_mem[r_rd_ptr];
  assign w_head_marker   = (w_head[20:17] == ACT_COMMIT);
  assign w_flush_word    = {6'b0, 5'b0, ACT_COMMIT, 3'b0, ~r_active_buf, 13'b0};
  // Sequencing is line-based only; column position is deliberately ignored.
  assign w_unused_hcount = ^bus.hcount;

  // Draw commands always target the back buffer, whatever the host put in bit 13.
  always_comb begin
    w_cmd_out = w_head;
    if (w_head[20:17] == ACT_DRAW) begin
      w_cmd_out[13] = ~r_active_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_writedata  <= '0;
      r_active_buf <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_writedata  <= '0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_vblank) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!w_vblank) begin
            r_state <= IDLE;
          end else if (w_empty) begin
            r_state <= WAIT_ACTIVE;
          end else if (w_head_marker) begin
            r_state <= FLUSH;
          end else begin
            r_writedata <= w_cmd_out;
          end
        end
        FLUSH: begin
          r_writedata  <= w_flush_word;
          r_active_buf <= ~r_active_buf;
          r_frame_done <= 1'b1;
          r_state      <= WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          if (!w_vblank) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = w_ready;
  assign bus.writedata  = r_writedata;
  assign bus.active_buf = r_active_buf;
  assign bus.fifo_count = r_count;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_cmd_sched.sv
// Randomized scoreboard bench for display_cmd_sched: a frame-level reference model predicts
// the ordered non-zero bus words; a negedge monitor consumes and compares them.
module tb_display_cmd_sched;
  localparam int         DEPTH = 16;
  localparam logic [9:0] VB    = 10'd480;

  typedef struct {
    logic [31:0] data;
    bit          flip;
    bit          abuf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_cmd_sched_if #(.FIFO_DEPTH(DEPTH)) bus ();

  display_cmd_sched #(.FIFO_DEPTH(DEPTH), .VBLANK_START(VB)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  bit          m_abuf = 1'b0;
  int          tests  = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.hcount = 10'($urandom_range(0, 799));
  endtask

  function automatic logic [31:0] rand_word(input bit allow_marker);
    logic [31:0] w;
    int          r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 3)                      w[20:17] = 4'h1;
    else if (r == 3 && allow_marker) w[20:17] = 4'hF;
    else if (w[20:17] == 4'hF)      w[20:17] = 4'h2;
    if (w == 32'h0) w = 32'h1;
    return w;
  endfunction

  // Frame-level model: a vblank of n cycles gives n-1 pop opportunities; drain stops at a marker.
  task automatic model_frame(input int budget);
    logic [31:0] w;
    while (budget > 0 && mq.size() > 0) begin
      w = mq.pop_front();
      budget--;
      if (w[20:17] == 4'hF) begin
        exp_q.push_back('{data: {11'b0, 4'hF, 3'b0, ~m_abuf, 13'b0}, flip: 1'b1, abuf: ~m_abuf});
        m_abuf = ~m_abuf;
        break;
      end
      if (w[20:17] == 4'h1) w[13] = ~m_abuf;
      exp_q.push_back('{data: w, flip: 1'b0, abuf: m_abuf});
    end
  endtask

  // Leaves cmd_valid high so back-to-back calls form a held-valid burst.
  task automatic push1(input logic [31:0] w);
    chk("cmd_ready_pre_push", bus.cmd_ready, (mq.size() != DEPTH));
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    if (mq.size() < DEPTH) mq.push_back(w);
    tick();
  endtask

  task automatic frame(input int n);
    model_frame(n - 1);
    for (int i = 0; i < n; i++) begin
      bus.vcount = VB + 10'($urandom_range(0, 44));
      tick();
    end
    bus.vcount = 10'd479;
    tick();
    bus.vcount = 10'($urandom_range(0, 479));
    tick();
    tick();
  endtask

  task automatic do_reset();
    chk("exp_q_empty_at_reset", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    chk("rst_writedata", bus.writedata, 32'h0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_active_buf", bus.active_buf, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    mq.delete();
    m_abuf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.writedata != 32'h0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h expected no output", bus.writedata);
        end else begin
          e = exp_q.pop_front();
          chk("writedata", bus.writedata, e.data);
          chk("frame_done_with_word", bus.frame_done, e.flip);
          chk("active_buf_with_word", bus.active_buf, e.abuf);
        end
      end else begin
        chk("frame_done_when_idle", bus.frame_done, 0);
      end
    end
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 32'h0;
    bus.hcount    = 10'd0;
    bus.vcount    = 10'd0;
    #2;
    do_reset();

    // Basic draw/draw/commit sequence from the datasheet example.
    bus.vcount = 10'd100;
    push1(32'h3C020001);
    push1(32'h3C024005);
    push1(32'h001E0000);
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("no_output_before_vblank", bus.writedata, 32'h0);
    model_frame(9);
    bus.vcount = 10'd480;
    tick();
    tick();
    chk("ex_cmd1", bus.writedata, 32'h3C022001);
    tick();
    chk("ex_cmd2", bus.writedata, 32'h3C026005);
    tick();
    chk("ex_marker_gap", bus.writedata, 32'h0);
    tick();
    chk("ex_flush", bus.writedata, 32'h001E2000);
    chk("ex_frame_done", bus.frame_done, 1);
    chk("ex_active_buf", bus.active_buf, 1);
    tick();
    chk("ex_frame_done_pulse", bus.frame_done, 0);
    for (int i = 0; i < 4; i++) tick();
    bus.vcount = 10'd200;
    tick();
    tick();
    tick();

    // FIFO full: 17 held-valid pushes, 16 accepted.
    do_reset();
    bus.vcount = 10'd200;
    for (int i = 0; i < 17; i++) push1(rand_word(1'b0));
    bus.cmd_valid = 1'b0;
    chk("full_fifo_count", bus.fifo_count, 16);
    chk("full_cmd_ready", bus.cmd_ready, 0);
    model_frame(3);
    bus.vcount = 10'd500;
    tick();
    tick();
    chk("full_ready_after_pop", bus.cmd_ready, 1);
    chk("full_count_after_pop", bus.fifo_count, 15);
    tick();
    tick();
    bus.vcount = 10'd10;
    tick();
    tick();
    tick();
    chk("full_count_after_frame", bus.fifo_count, mq.size());

    // Short vblank: 5 queued, only 2 pops fit, rest next frame, no flip.
    do_reset();
    bus.vcount = 10'd300;
    for (int i = 0; i < 5; i++) push1(rand_word(1'b0));
    bus.cmd_valid = 1'b0;
    tick();
    frame(3);
    chk("partial_fifo_count", bus.fifo_count, 3);
    chk("partial_no_flip", bus.active_buf, 0);
    frame(20);
    chk("partial_rest_count", bus.fifo_count, 0);
    chk("partial_rest_no_flip", bus.active_buf, 0);

    // Push coinciding with a DRAIN pop.
    bus.vcount = 10'd300;
    for (int i = 0; i < 3; i++) push1(rand_word(1'b0));
    bus.cmd_valid = 1'b0;
    tick();
    begin
      logic [31:0] x;
      x = rand_word(1'b0);
      mq.push_back(x);
      model_frame(9);
      bus.vcount = 10'd480;
      tick();
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = x;
      tick();
      bus.cmd_valid = 1'b0;
      chk("push_pop_count", bus.fifo_count, 3);
      for (int i = 0; i < 8; i++) tick();
      bus.vcount = 10'd0;
      tick();
      tick();
      tick();
      chk("push_pop_drained", bus.fifo_count, 0);
    end

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      int k;
      k = $urandom_range(0, 10);
      for (int i = 0; i < k; i++) begin
        bus.vcount = 10'($urandom_range(0, 479));
        if ($urandom_range(0, 2) == 0) begin
          bus.cmd_valid = 1'b0;
          tick();
        end else begin
          push1(rand_word(1'b1));
        end
      end
      bus.cmd_valid = 1'b0;
      tick();
      chk("rand_count_pre", bus.fifo_count, mq.size());
      frame($urandom_range(2, 22));
      chk("rand_count_post", bus.fifo_count, mq.size());
      chk("rand_active_buf", bus.active_buf, m_abuf);
    end

    // Empty leftovers so the reset-in-DRAIN case starts from a known queue.
    for (int g = 0; g < 40 && mq.size() > 0; g++) frame(40);
    chk("residue_drained", bus.fifo_count, 0);

    // Reset in DRAIN with 4 words (3 commands + marker) still queued.
    bus.vcount = 10'd100;
    for (int i = 0; i < 5; i++) push1(rand_word(1'b0));
    push1(32'h001E0000);
    bus.cmd_valid = 1'b0;
    tick();
    model_frame(2);
    bus.vcount = 10'd480;
    tick();
    tick();
    tick();
    chk("pre_reset_count", bus.fifo_count, 4);
    @(negedge clk);
    #2;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    bus.vcount = 10'd50;
    tick();
    tick();
    tick();
    chk("post_reset_count", bus.fifo_count, 0);
    chk("post_reset_active_buf", bus.active_buf, 0);

    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
